// File: rtl/sgd_dot_scheduler_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : sgd_sched_pkg                                                |
// | Purpose : Shared types for the dot-product adder-tree scheduler.       |
// |           FSM state encoding, the tag that travels alongside each      |
// |           chunk through the tree, and the datapath word width.         |
// | Ports   : none (package)                                               |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package sgd_sched_pkg;

   localparam int DATA_W   = 32;
   // Tag id field is sized for the largest bank count we expect to build;
   // the top truncates it to its own ID_WIDTH on the way out.
   localparam int TAG_ID_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } sched_state_t;

   typedef struct packed {
      logic                valid;
      logic [TAG_ID_W-1:0] id;
      logic                last;
   } tag_t;

endpackage
`default_nettype wire

// File: rtl/sgd_dot_scheduler_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface: sgd_dot_scheduler_if                                        |
// | Purpose  : Bundles the bank request bus, the adder-tree bus and the    |
// |            result bus of the dot-product scheduler.                    |
// | Modports : slave  - the scheduler (accepts bank chunks, drives tree    |
// |                     inputs and results)                                |
// |            master - the surroundings (banks, adder tree, consumer)     |
// | Signals  : req_valid/req_last/req_data/req_ready  bank handshake       |
// |            tree_in/tree_in_valid/tree_out/tree_out_valid  shared tree  |
// |            res_data/res_id/res_valid  completed dot products           |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
interface sgd_dot_scheduler_if #(
   parameter int NUM_REQ    = 4,
   parameter int ID_WIDTH   = 2,
   parameter int TREE_WIDTH = 8
) ();
   import sgd_sched_pkg::*;

   logic [NUM_REQ-1:0]                             req_valid;
   logic [NUM_REQ-1:0]                             req_last;
   logic [NUM_REQ-1:0][TREE_WIDTH-1:0][DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]                             req_ready;

   logic [TREE_WIDTH-1:0][DATA_W-1:0]              tree_in;
   logic                                           tree_in_valid;
   logic [DATA_W-1:0]                              tree_out;
   logic                                           tree_out_valid;

   logic [DATA_W-1:0]                              res_data;
   logic [ID_WIDTH-1:0]                            res_id;
   logic                                           res_valid;

   modport slave (
      input  req_valid, req_last, req_data, tree_out, tree_out_valid,
      output req_ready, tree_in, tree_in_valid, res_data, res_id, res_valid
   );

   modport master (
      output req_valid, req_last, req_data, tree_out, tree_out_valid,
      input  req_ready, tree_in, tree_in_valid, res_data, res_id, res_valid
   );

endinterface
`default_nettype wire

// File: rtl/sgd_dot_scheduler_arb.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : sgd_rr_arbiter                                               |
// | Purpose : Combinational round-robin arbiter. Searches req starting at  |
// |           ptr+1 (wrapping) and grants the first requester found.       |
// | Ports   : req   in  [NUM_REQ]  request vector                          |
// |           ptr   in  ID_WIDTH   last granted index                      |
// |           grant out [NUM_REQ]  one-hot grant, zero if no request       |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module sgd_rr_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int ID_WIDTH = 2
) (
   input  wire logic [NUM_REQ-1:0]  req,
   input  wire logic [ID_WIDTH-1:0] ptr,
   output logic      [NUM_REQ-1:0]  grant
);

   logic [ID_WIDTH-1:0] w_idx;
   logic                w_found;

   // Offsets 1..NUM_REQ visit every bank once, ending on ptr itself, so a
   // lone requester that was just served is still granted again.
   always_comb begin
      grant   = '0;
      w_found = 1'b0;
      w_idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_idx = ID_WIDTH'((int'(ptr) + k) % NUM_REQ);
         if (!w_found && req[w_idx]) begin
            grant[w_idx] = 1'b1;
            w_found      = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/sgd_dot_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : sgd_dot_scheduler                                            |
// | Purpose : Shares one pipelined adder tree among NUM_REQ dot-product    |
// |           banks. Grants one chunk per cycle round-robin, tags it with  |
// |           {valid, id, last}, accumulates the returning tree sums per   |
// |           bank and emits the finished dot product on the last chunk.   |
// | Ports   : clk, rst_n (async, active low)                               |
// |           start  in  pulse IDLE->RUN                                   |
// |           stop   in  pulse RUN->DRAIN (wins over start)                |
// |           busy   out high in RUN/DRAIN                                 |
// |           done   out one-cycle pulse on DRAIN->IDLE                    |
// |           tag_err out sticky: tree_out_valid disagreed with head tag   |
// |           bus    slave modport: bank requests, tree bus, results       |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module sgd_dot_scheduler
   import sgd_sched_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int ID_WIDTH     = 2,
   parameter int TREE_WIDTH   = 8,
   parameter int TREE_LATENCY = 2
) (
   input  wire logic            clk,
   input  wire logic            rst_n,
   input  wire logic            start,
   input  wire logic            stop,
   output logic                 busy,
   output logic                 done,
   output logic                 tag_err,
   sgd_dot_scheduler_if.slave   bus
);

   sched_state_t                      r_state;
   logic                              r_busy;
   logic                              r_done;
   logic [ID_WIDTH-1:0]               r_rr_ptr;
   logic [TREE_WIDTH-1:0][DATA_W-1:0] r_tree_in;
   // r_tag[0] sits alongside tree_in; r_tag[TREE_LATENCY] lines up with
   // tree_out, so the head is TREE_LATENCY stages behind the issue stage.
   tag_t                              r_tag [TREE_LATENCY+1];
   logic [DATA_W-1:0]                 r_acc [NUM_REQ];
   logic [DATA_W-1:0]                 r_res_data;
   logic [ID_WIDTH-1:0]               r_res_id;
   logic                              r_res_valid;
   logic                              r_tag_err;

   logic [NUM_REQ-1:0]                w_grant;
   logic [NUM_REQ-1:0]                w_ready;
   logic                              w_xfer;
   logic [ID_WIDTH-1:0]               w_gnt_id;
   tag_t                              w_issue_tag;
   tag_t                              w_head;
   logic [ID_WIDTH-1:0]               w_head_id;
   logic [DATA_W-1:0]                 w_sum;
   logic                              w_pipe_empty;

   sgd_rr_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_arb (
      .req   (bus.req_valid),
      .ptr   (r_rr_ptr),
      .grant (w_grant)
   );

   // Grants are only exposed while running; IDLE and DRAIN hold them off.
   assign w_ready = (r_state == ST_RUN) ? w_grant : '0;
   assign w_xfer  = |(w_ready & bus.req_valid);

   always_comb begin
      w_gnt_id = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_ready[i]) begin
            w_gnt_id = ID_WIDTH'(i);
         end
      end
   end

   always_comb begin
      w_issue_tag       = '0;
      w_issue_tag.valid = w_xfer;
      w_issue_tag.id    = TAG_ID_W'(w_gnt_id);
      w_issue_tag.last  = w_xfer & bus.req_last[w_gnt_id];
   end

   assign w_head    = r_tag[TREE_LATENCY];
   assign w_head_id = ID_WIDTH'(w_head.id);
   // Plain unsigned add gives two's-complement wrap with no saturation.
   assign w_sum     = r_acc[w_head_id] + bus.tree_out;

   always_comb begin
      w_pipe_empty = 1'b1;
      for (int s = 0; s <= TREE_LATENCY; s++) begin
         if (r_tag[s].valid) begin
            w_pipe_empty = 1'b0;
         end
      end
   end

   // Control FSM with registered busy/done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_state <= ST_RUN;
                  r_busy  <= 1'b1;
               end
            end
            ST_RUN: begin
               if (stop) begin
                  r_state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (w_pipe_empty) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Round-robin pointer only moves on an actual transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr <= ID_WIDTH'(NUM_REQ - 1);
      end else if (w_xfer) begin
         r_rr_ptr <= w_gnt_id;
      end
   end

   // Issue stage and tag pipeline.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tree_in <= '0;
         for (int s = 0; s <= TREE_LATENCY; s++) begin
            r_tag[s] <= '0;
         end
      end else begin
         if (w_xfer) begin
            r_tree_in <= bus.req_data[w_gnt_id];
         end
         r_tag[0] <= w_issue_tag;
         for (int s = 1; s <= TREE_LATENCY; s++) begin
            r_tag[s] <= r_tag[s-1];
         end
      end
   end

   // Retire: the head tag alone decides what happens to tree_out, so a
   // spurious tree_out_valid only raises tag_err and never disturbs acc.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < NUM_REQ; b++) begin
            r_acc[b] <= '0;
         end
         r_res_data  <= '0;
         r_res_id    <= '0;
         r_res_valid <= 1'b0;
         r_tag_err   <= 1'b0;
      end else begin
         r_res_valid <= 1'b0;
         if (bus.tree_out_valid != w_head.valid) begin
            r_tag_err <= 1'b1;
         end
         if (w_head.valid) begin
            if (w_head.last) begin
               r_res_data       <= w_sum;
               r_res_id         <= w_head_id;
               r_res_valid      <= 1'b1;
               r_acc[w_head_id] <= '0;
            end else begin
               r_acc[w_head_id] <= w_sum;
            end
         end
      end
   end

   assign bus.req_ready     = w_ready;
   assign bus.tree_in       = r_tree_in;
   assign bus.tree_in_valid = r_tag[0].valid;
   assign bus.res_data      = r_res_data;
   assign bus.res_id        = r_res_id;
   assign bus.res_valid     = r_res_valid;
   assign busy              = r_busy;
   assign done              = r_done;
   assign tag_err           = r_tag_err;

endmodule
`default_nettype wire

// File: tb/tb_sgd_dot_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_sgd_dot_scheduler                                         |
// | Purpose : Self-checking bench for sgd_dot_scheduler. Per-cycle vector  |
// |           table with hand-computed expectations, a two-stage adder     |
// |           tree model, and hand-written tree-glitch / drain sequences.  |
// | Ports   : none                                                         |
// | Revision: 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_sgd_dot_scheduler;
   import sgd_sched_pkg::*;

   localparam int NUM_REQ      = 4;
   localparam int ID_WIDTH     = 2;
   localparam int TREE_WIDTH   = 8;
   localparam int TREE_LATENCY = 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic stop  = 1'b0;
   logic busy;
   logic done;
   logic tag_err;

   int n_cmp = 0;
   int n_err = 0;

   sgd_dot_scheduler_if #(
      .NUM_REQ    (NUM_REQ),
      .ID_WIDTH   (ID_WIDTH),
      .TREE_WIDTH (TREE_WIDTH)
   ) bus ();

   sgd_dot_scheduler #(
      .NUM_REQ      (NUM_REQ),
      .ID_WIDTH     (ID_WIDTH),
      .TREE_WIDTH   (TREE_WIDTH),
      .TREE_LATENCY (TREE_LATENCY)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .stop    (stop),
      .busy    (busy),
      .done    (done),
      .tag_err (tag_err),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Adder tree model: lane sum, two register stages.
   logic [31:0] lane_sum;
   logic [31:0] t_s1, t_s2;
   logic        t_v1, t_v2;
   logic        glitch = 1'b0;

   always_comb begin
      lane_sum = '0;
      for (int l = 0; l < TREE_WIDTH; l++) begin
         lane_sum = lane_sum + bus.tree_in[l];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         t_s1 <= '0; t_s2 <= '0; t_v1 <= 1'b0; t_v2 <= 1'b0;
      end else begin
         t_s1 <= lane_sum;
         t_v1 <= bus.tree_in_valid;
         t_s2 <= t_s1;
         t_v2 <= t_v1;
      end
   end

   assign bus.tree_out       = t_s2;
   assign bus.tree_out_valid = t_v2 | glitch;

   typedef struct {
      bit              rst;
      bit              start;
      bit              stop;
      logic [3:0]      valid;
      logic [3:0]      last;
      logic [3:0][31:0] val;
      bit              lane0_only;
      logic [3:0]      exp_ready;
      bit              exp_rv;
      logic [31:0]     exp_data;
      logic [1:0]      exp_id;
      bit              exp_busy;
      bit              exp_done;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input bit r, input bit st, input bit sp,
                      input logic [3:0] va, input logic [3:0] la,
                      input logic [31:0] v0, input logic [31:0] v1,
                      input logic [31:0] v2, input logic [31:0] v3,
                      input bit l0, input logic [3:0] er, input bit erv,
                      input logic [31:0] ed, input logic [1:0] eid,
                      input bit eb, input bit edn);
      vec_t v;
      v.rst = r; v.start = st; v.stop = sp; v.valid = va; v.last = la;
      v.val[0] = v0; v.val[1] = v1; v.val[2] = v2; v.val[3] = v3;
      v.lane0_only = l0; v.exp_ready = er; v.exp_rv = erv;
      v.exp_data = ed; v.exp_id = eid; v.exp_busy = eb; v.exp_done = edn;
      vecs.push_back(v);
   endtask

   task automatic nop(input bit eb, input bit erv, input logic [31:0] ed,
                      input logic [1:0] eid, input bit edn);
      add(0, 0, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, erv, ed, eid, eb, edn);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst_n = !v.rst;
      start = v.start;
      stop  = v.stop;
      bus.req_valid = v.valid;
      bus.req_last  = v.last;
      for (int b = 0; b < NUM_REQ; b++) begin
         for (int l = 0; l < TREE_WIDTH; l++) begin
            bus.req_data[b][l] = (v.lane0_only && l != 0) ? 32'd0 : v.val[b];
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit got;
      bus.req_valid = '0;
      bus.req_last  = '0;
      bus.req_data  = '0;

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst busy",          32'(busy), 32'd0);
      check("rst done",          32'(done), 32'd0);
      check("rst req_ready",     32'(bus.req_ready), 32'd0);
      check("rst tree_in_valid", 32'(bus.tree_in_valid), 32'd0);
      check("rst tree_in_nz",    32'(|bus.tree_in), 32'd0);
      check("rst res_data",      bus.res_data, 32'd0);
      check("rst res_id",        32'(bus.res_id), 32'd0);
      check("rst res_valid",     32'(bus.res_valid), 32'd0);
      check("rst tag_err",       32'(tag_err), 32'd0);
      @(posedge clk); #1;

      // Single bank, two chunks of ones -> 16
      add(0,1,0, 4'b0000,4'b0000, 0,0,0,0, 0, 4'b0000, 0,0,0, 0,0);
      add(0,0,0, 4'b0001,4'b0000, 1,0,0,0, 0, 4'b0001, 0,0,0, 1,0);
      add(0,0,0, 4'b0001,4'b0001, 1,0,0,0, 0, 4'b0001, 0,0,0, 1,0);
      nop(1,0,0,0,0); nop(1,0,0,0,0); nop(1,0,0,0,0);
      nop(1,1,16,0,0); nop(1,0,0,0,0);

      // Reset, then four banks racing: grants 0,1,2,3,0,1,2,3
      add(1,0,0, 4'b0000,4'b0000, 0,0,0,0, 0, 4'b0000, 0,0,0, 0,0);
      add(0,1,0, 4'b0000,4'b0000, 0,0,0,0, 0, 4'b0000, 0,0,0, 0,0);
      add(0,0,0, 4'b1111,4'b0000, 1,2,3,4, 0, 4'b0001, 0,0,0, 1,0);
      add(0,0,0, 4'b1111,4'b0001, 1,2,3,4, 0, 4'b0010, 0,0,0, 1,0);
      add(0,0,0, 4'b1111,4'b0011, 1,2,3,4, 0, 4'b0100, 0,0,0, 1,0);
      add(0,0,0, 4'b1111,4'b0111, 1,2,3,4, 0, 4'b1000, 0,0,0, 1,0);
      add(0,0,0, 4'b1111,4'b1111, 1,2,3,4, 0, 4'b0001, 0,0,0, 1,0);
      add(0,0,0, 4'b1110,4'b1110, 1,2,3,4, 0, 4'b0010, 0,0,0, 1,0);
      add(0,0,0, 4'b1100,4'b1100, 1,2,3,4, 0, 4'b0100, 0,0,0, 1,0);
      add(0,0,0, 4'b1000,4'b1000, 1,2,3,4, 0, 4'b1000, 0,0,0, 1,0);
      nop(1,1,16,0,0); nop(1,1,32,1,0); nop(1,1,48,2,0); nop(1,1,64,3,0);
      nop(1,0,0,0,0);

      // Interleaved with negatives: bank1 = -24+40, bank2 = 56
      add(0,0,0, 4'b0110,4'b0100, 0,-3,7,0, 0, 4'b0010, 0,0,0, 1,0);
      add(0,0,0, 4'b0110,4'b0110, 0, 5,7,0, 0, 4'b0100, 0,0,0, 1,0);
      add(0,0,0, 4'b0010,4'b0010, 0, 5,0,0, 0, 4'b0010, 0,0,0, 1,0);
      nop(1,0,0,0,0); nop(1,0,0,0,0);
      nop(1,1,56,2,0); nop(1,1,16,1,0); nop(1,0,0,0,0);

      // Wrap: 0x7FFFFFFF + 1
      add(0,0,0, 4'b0001,4'b0000, 32'h7FFFFFFF,0,0,0, 1, 4'b0001, 0,0,0, 1,0);
      add(0,0,0, 4'b0001,4'b0001, 1,0,0,0,            1, 4'b0001, 0,0,0, 1,0);
      nop(1,0,0,0,0); nop(1,0,0,0,0); nop(1,0,0,0,0);
      nop(1,1,32'h80000000,0,0); nop(1,0,0,0,0);

      // Three single-chunk samples in flight, then stop and drain
      add(0,0,0, 4'b1110,4'b1110, 0,1,2,3, 0, 4'b0010, 0,0,0, 1,0);
      add(0,0,0, 4'b1100,4'b1100, 0,1,2,3, 0, 4'b0100, 0,0,0, 1,0);
      add(0,0,0, 4'b1000,4'b1000, 0,1,2,3, 0, 4'b1000, 0,0,0, 1,0);
      add(0,0,1, 4'b0000,4'b0000, 0,0,0,0, 0, 4'b0000, 0,0,0, 1,0);
      add(0,1,0, 4'b0001,4'b0000, 9,0,0,0, 0, 4'b0000, 1,8,1, 1,0);
      add(0,0,0, 4'b0001,4'b0000, 9,0,0,0, 0, 4'b0000, 1,16,2, 1,0);
      add(0,0,0, 4'b0001,4'b0000, 9,0,0,0, 0, 4'b0000, 1,24,3, 1,0);
      add(0,0,0, 4'b0001,4'b0000, 9,0,0,0, 0, 4'b0000, 0,0,0, 0,1);
      // stop in IDLE ignored; start+stop in RUN goes to DRAIN
      add(0,0,1, 4'b0000,4'b0000, 0,0,0,0, 0, 4'b0000, 0,0,0, 0,0);
      add(0,1,0, 4'b0000,4'b0000, 0,0,0,0, 0, 4'b0000, 0,0,0, 0,0);
      add(0,1,1, 4'b0000,4'b0000, 0,0,0,0, 0, 4'b0000, 0,0,0, 1,0);
      add(0,0,0, 4'b0001,4'b0000, 9,0,0,0, 0, 4'b0000, 0,0,0, 1,0);
      nop(0,0,0,0,1); nop(0,0,0,0,0);

      // Partial sums pending, reset, next sample must be clean (8, not 48)
      add(0,1,0, 4'b0000,4'b0000, 0,0,0,0, 0, 4'b0000, 0,0,0, 0,0);
      add(0,0,0, 4'b0001,4'b0000, 5,0,0,0, 0, 4'b0001, 0,0,0, 1,0);
      add(0,0,0, 4'b0001,4'b0000, 5,0,0,0, 0, 4'b0001, 0,0,0, 1,0);
      nop(1,0,0,0,0); nop(1,0,0,0,0);
      add(1,0,0, 4'b0000,4'b0000, 0,0,0,0, 0, 4'b0000, 0,0,0, 0,0);
      add(0,1,0, 4'b0000,4'b0000, 0,0,0,0, 0, 4'b0000, 0,0,0, 0,0);
      add(0,0,0, 4'b0001,4'b0001, 1,0,0,0, 0, 4'b0001, 0,0,0, 1,0);
      nop(1,0,0,0,0); nop(1,0,0,0,0); nop(1,0,0,0,0);
      nop(1,1,8,0,0); nop(1,0,0,0,0);

      for (int k = 0; k < vecs.size(); k++) begin
         drive(vecs[k]);
         @(negedge clk);
         check($sformatf("v%0d req_ready", k), 32'(bus.req_ready), 32'(vecs[k].exp_ready));
         check($sformatf("v%0d busy", k),      32'(busy), 32'(vecs[k].exp_busy));
         check($sformatf("v%0d done", k),      32'(done), 32'(vecs[k].exp_done));
         check($sformatf("v%0d res_valid", k), 32'(bus.res_valid), 32'(vecs[k].exp_rv));
         check($sformatf("v%0d tag_err", k),   32'(tag_err), 32'd0);
         if (vecs[k].exp_rv) begin
            check($sformatf("v%0d res_data", k), bus.res_data, vecs[k].exp_data);
            check($sformatf("v%0d res_id", k),   32'(bus.res_id), 32'(vecs[k].exp_id));
         end
         if (vecs[k].rst) begin
            check($sformatf("v%0d rst res_data", k), bus.res_data, 32'd0);
            check($sformatf("v%0d rst res_id", k),   32'(bus.res_id), 32'd0);
            check($sformatf("v%0d rst tiv", k),      32'(bus.tree_in_valid), 32'd0);
            check($sformatf("v%0d rst tree_in", k),  32'(|bus.tree_in), 32'd0);
         end
         @(posedge clk); #1;
      end

      // Tree glitch with an empty tag pipeline (state RUN, nothing issued)
      rst_n = 1'b1; start = 1'b0; stop = 1'b0;
      bus.req_valid = '0; bus.req_last = '0;
      glitch = 1'b1;
      @(posedge clk); #1;
      glitch = 1'b0;
      @(negedge clk);
      check("glitch tag_err set",  32'(tag_err), 32'd1);
      check("glitch no res_valid", 32'(bus.res_valid), 32'd0);
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("glitch tag_err sticky", 32'(tag_err), 32'd1);

      // Stop and wait (bounded) for done
      @(posedge clk); #1;
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (done) got = 1'b1;
      end
      check("drain done seen", 32'(got), 32'd1);
      check("tag_err held through done", 32'(tag_err), 32'd1);

      // Only reset clears tag_err
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(negedge clk);
      check("reset clears tag_err", 32'(tag_err), 32'd0);
      check("reset busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sgd_dot_scheduler.md
# sgd_dot_scheduler

Round-robin scheduler that shares one pipelined 32-bit signed adder tree among `NUM_REQ` dot-product banks. Each bank streams `TREE_WIDTH`-wide chunks of per-feature products. The scheduler grants one chunk per cycle into the tree and tags it with its bank id and last flag. When the tree output returns, it adds the output into that bank's running sum and emits the completed sum on the bank's last chunk. The block sits between the bank multipliers and the gradient/loss logic, and sequences start, run and drain of the shared tree.

## Interface
- `NUM_REQ`, 4 — number of requesting banks (≥2)
- `ID_WIDTH`, 2 — `$clog2(NUM_REQ)`
- `TREE_WIDTH`, 8 — lanes per chunk
- `TREE_LATENCY`, 2 — cycles from `tree_in_valid` to `tree_out_valid`

Ports:
- `clk` in 1 — clock
- `rst_n` in 1 — asynchronous, active-low reset
- `start` in 1 — pulse: IDLE→RUN
- `stop` in 1 — pulse: RUN→DRAIN
- `busy` out 1 — high in RUN or DRAIN
- `done` out 1 — one-cycle pulse on DRAIN→IDLE
- `req_valid` in [NUM_REQ] — bank i has a chunk
- `req_last` in [NUM_REQ] — chunk is the last of bank i's sample
- `req_data` in [NUM_REQ][TREE_WIDTH] x 32 signed — chunk lanes
- `req_ready` out [NUM_REQ] — grant; combinational, one-hot or zero
- `tree_in` out [TREE_WIDTH] x 32 signed — to adder tree
- `tree_in_valid` out 1 — to adder tree
- `tree_out` in 32 signed — from adder tree
- `tree_out_valid` in 1 — from adder tree
- `res_data` out 32 signed — completed dot product
- `res_id` out ID_WIDTH — bank owning `res_data`
- `res_valid` out 1 — one-cycle pulse, no backpressure
- `tag_err` out 1 — sticky; `tree_out_valid` disagrees with the tag pipeline

## Operation
- FSM states IDLE, RUN, DRAIN.
  - IDLE: no grants. `start`→RUN.
  - RUN: arbitrate. `stop`→DRAIN. If `start` and `stop` arrive in the same cycle, `stop` wins.
  - DRAIN: no grants. When the tag pipeline and in-flight register are empty, go to IDLE and pulse `done`.
  - `start` outside IDLE and `stop` outside RUN are ignored.
- Arbitration (RUN only):
  - Round-robin over `req_valid`, starting at `rr_ptr+1`.
  - A grant is combinational on `req_ready[i]`. A transfer occurs when `req_valid[i] & req_ready[i]`.
  - After a transfer, `rr_ptr` becomes i. With no transfer, `rr_ptr` holds.
  - Interleaving banks chunk-by-chunk is legal.
- Issue:
  - At the transfer edge, `tree_in`, `tree_in_valid` and the tag {valid, id, last} are registered.
  - Tags shift through a `TREE_LATENCY`-deep pipeline aligned with the tree.
- Retire, when the tag at the pipeline head is valid:
  - If not last: `acc[id] <= acc[id] + tree_out`.
  - If last: `res_data <= acc[id] + tree_out`, `res_id <= id`, `res_valid <= 1`, `acc[id] <= 0`.
  - Arithmetic is 32-bit two's complement with wrap and no saturation.
- Tag error: `tree_out_valid != head tag valid` sets `tag_err`. It clears only on reset. Retire is driven by the tag, not by `tree_out_valid`.
- A chunk whose last flag is set starts and ends a sample, so a single-chunk sample is legal.
- `acc` is not cleared by `stop` or `done`. An unfinished sample persists into the next RUN.

## Timing
- Transfer at edge t:
  - `tree_in_valid` is high in cycle t+1.
  - `tree_out_valid` arrives at t+1+`TREE_LATENCY`.
  - `res_valid` is high in cycle t+2+`TREE_LATENCY` (4 with defaults).
- Throughput: one chunk per cycle, at most one `res_valid` per cycle, so no result collisions.
- DRAIN lasts at least 1 + `TREE_LATENCY` cycles after the last transfer.
- Reset values:
  - outputs: `busy` 0, `done` 0, `req_ready` 0, `tree_in` all 0, `tree_in_valid` 0, `res_data` 0, `res_id` 0, `res_valid` 0, `tag_err` 0.
  - internal: all `acc` 0, tags invalid, `rr_ptr` = NUM_REQ-1 (bank 0 has first priority), FSM IDLE.
- Reset asserted mid-operation discards in-flight tags and partial sums immediately.

## Structure
- Package `sgd_sched_pkg`: FSM state enum, tag struct {valid, id, last}, `DATA_W=32`.
- One sub-module, `sgd_rr_arbiter` (NUM_REQ; inputs `req`, `ptr`; output one-hot `grant`), purely combinational.
- Tag pipeline, accumulators and FSM live in the top.

## Test plan
- Single bank: bank 0 sends 2 chunks, all lanes 1, last on the second. Expect `res_valid` with `res_data`=16, `res_id`=0, 4 cycles after the second transfer.
- Four banks all valid: grants go 0,1,2,3,0. Bank i sends lanes = i+1, 2 chunks each. Expect results 16, 32, 48, 64 with matching ids, one per cycle.
- Interleaved and negative values: bank 1 sends lanes −3 then 5, bank 2 sends lanes 7 only. Expect bank 1 `res_data`=16 and bank 2 `res_data`=56, with no cross-contamination.
- Wrap: two chunks where lane 0 = 0x7FFFFFFF and the rest are 0, then lane 0 = 1. Expect `res_data`=0x80000000.
- `stop` with 3 chunks in flight: `req_ready` drops immediately. All 3 retire, then `done` pulses and `busy` falls. `start`+`stop` in the same cycle in RUN → DRAIN.
- Reset mid-stream and tree glitch: assert `rst_n` low with partial sums pending. Expect all outputs 0 and the next sample's result to exclude stale data. Force `tree_out_valid` high with an empty pipeline. Expect `tag_err` to go high and stay high.
